coprocessor_responder: RTL and testbench

//  Coprocessor-side end of the core's dispatch interface: accepts a held cp_valid request
//  (instruction, rs1 operand, 2-bit unit select), launches one of CP_NUM execution units via a

---
 rtl/coprocessor_responder.sv | 128 ++++++++++++
 tb/tb_coprocessor_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/coprocessor_responder.sv
// Coprocessor-side dispatch responder: accepts a held request, launches the selected
// execution unit, and returns its result, a bad-select exception or a timeout exception.
module coprocessor_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int INST_WIDTH     = 32,
  parameter int CP_NUM         = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cp_valid,
  input  logic [INST_WIDTH-1:0]        cp_instruction,
  input  logic [DATA_WIDTH-1:0]        cp_data_in,
  input  logic [1:0]                   cp_select,
  output logic [DATA_WIDTH-1:0]        cp_data_out,
  output logic                         cp_ready,
  output logic                         cp_exception,
  output logic [CP_NUM-1:0]            unit_start,
  output logic [INST_WIDTH-1:0]        unit_instruction,
  output logic [DATA_WIDTH-1:0]        unit_operand,
  input  logic [CP_NUM-1:0]            unit_done,
  input  logic [CP_NUM-1:0]            unit_error,
  input  logic [CP_NUM*DATA_WIDTH-1:0] unit_result,
  output logic                         busy
);

  // state | meaning
  // IDLE  | waiting for cp_valid
  // BUSY  | selected unit started, waiting for its done or the timeout
  // DONE  | cp_ready held with result/exception until cp_valid completes the handshake
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] CP_NUM_W = 3'(CP_NUM);

  state_t                  state;
  logic [1:0]              sel_q;
  logic [CNT_W-1:0]        tmo_cnt;
  logic                    sel_done;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_result;
  logic                    select_ok;

  assign select_ok = ({1'b0, cp_select} < CP_NUM_W);

  // Only the latched unit's done/error/result are visible; others are ignored.
  always_comb begin
    sel_done   = 1'b0;
    sel_err    = 1'b0;
    sel_result = '0;
    for (int i = 0; i < CP_NUM; i++) begin
      if (sel_q == i[1:0]) begin
        sel_done   = unit_done[i];
        sel_err    = unit_error[i];
        sel_result = unit_result[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      sel_q            <= '0;
      tmo_cnt          <= '0;
      cp_data_out      <= '0;
      cp_ready         <= 1'b0;
      cp_exception     <= 1'b0;
      unit_start       <= '0;
      unit_instruction <= '0;
      unit_operand     <= '0;
      busy             <= 1'b0;
    end else begin
      unit_start <= '0;
      case (state)
        IDLE: begin
          if (cp_valid) begin
            unit_instruction <= cp_instruction;
            unit_operand     <= cp_data_in;
            sel_q            <= cp_select;
            busy             <= 1'b1;
            if (select_ok) begin
              state      <= BUSY;
              unit_start <= CP_NUM'(1) << cp_select;
              tmo_cnt    <= TMO_LOAD;
            end else begin
              state        <= DONE;
              cp_ready     <= 1'b1;
              cp_exception <= 1'b1;
              cp_data_out  <= '0;
            end
          end
        end
        BUSY: begin
          // A done arriving in the last allowed cycle still wins over the timeout.
          if (sel_done) begin
            state        <= DONE;
            cp_ready     <= 1'b1;
            cp_data_out  <= sel_result;
            cp_exception <= sel_err;
          end else if (tmo_cnt == '0) begin
            state        <= DONE;
            cp_ready     <= 1'b1;
            cp_data_out  <= '0;
            cp_exception <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        DONE: begin
          if (cp_valid) begin
            state        <= IDLE;
            busy         <= 1'b0;
            cp_ready     <= 1'b0;
            cp_exception <= 1'b0;
            cp_data_out  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          cp_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coprocessor_responder.sv
// Directed bench for coprocessor_responder: results, bad select, timeout, ignored units,
// back-to-back requests with held results, and reset mid-operation.
module tb_coprocessor_responder;

  localparam int DW = 32;
  localparam int IW = 32;
  localparam int NU = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cp_valid;
  logic [IW-1:0] cp_instruction;
  logic [DW-1:0] cp_data_in;
  logic [1:0]    cp_select;
  logic [DW-1:0] cp_data_out;
  logic          cp_ready;
  logic          cp_exception;
  logic [NU-1:0] unit_start;
  logic [IW-1:0] unit_instruction;
  logic [DW-1:0] unit_operand;
  logic [NU-1:0] unit_done;
  logic [NU-1:0] unit_error;
  logic [DW-1:0] res0, res1, res2;
  logic          busy;

  int errors = 0;
  int checks = 0;

  coprocessor_responder #(
    .DATA_WIDTH(DW), .INST_WIDTH(IW), .CP_NUM(NU), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cp_valid(cp_valid), .cp_instruction(cp_instruction),
    .cp_data_in(cp_data_in), .cp_select(cp_select), .cp_data_out(cp_data_out),
    .cp_ready(cp_ready), .cp_exception(cp_exception), .unit_start(unit_start),
    .unit_instruction(unit_instruction), .unit_operand(unit_operand),
    .unit_done(unit_done), .unit_error(unit_error), .unit_result({res2, res1, res0}),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic exc,
                         input logic [DW-1:0] data, input logic bsy);
    chk({tag, ".ready"}, 64'(cp_ready), 64'(rdy));
    chk({tag, ".exc"}, 64'(cp_exception), 64'(exc));
    chk({tag, ".data"}, 64'(cp_data_out), 64'(data));
    chk({tag, ".busy"}, 64'(busy), 64'(bsy));
  endtask

  initial begin
    rst_n = 1'b0; cp_valid = 1'b0; cp_instruction = '0; cp_data_in = '0; cp_select = '0;
    unit_done = '0; unit_error = '0; res0 = '0; res1 = '0; res2 = '0;
    tick(); tick();
    chk_out("reset", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset.start", 64'(unit_start), 64'h0);
    chk("reset.operand", 64'(unit_operand), 64'h0);
    chk("reset.instr", 64'(unit_instruction), 64'h0);
    rst_n = 1'b1;
    tick();

    // 1: sel=1, unit1 done at start+3
    cp_valid = 1'b1; cp_select = 2'd1; cp_data_in = 32'h12345678; cp_instruction = 32'h0000_00A1;
    tick();
    chk("t1.start", 64'(unit_start), 64'h2);
    chk("t1.operand", 64'(unit_operand), 64'h12345678);
    chk("t1.instr", 64'(unit_instruction), 64'hA1);
    chk_out("t1.busy1", 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("t1.start_once", 64'(unit_start), 64'h0);
    tick(); tick();
    chk("t1.not_ready", 64'(cp_ready), 64'h0);
    unit_done = 3'b010; res1 = 32'hCAFEF00D; res0 = 32'hDEADBEEF;
    tick();
    unit_done = '0;
    chk_out("t1.done", 1'b1, 1'b0, 32'hCAFEF00D, 1'b1);
    tick();
    cp_valid = 1'b0;
    chk_out("t1.idle", 1'b0, 1'b0, 32'h0, 1'b0);

    // 2: invalid select
    cp_valid = 1'b1; cp_select = 2'd3; cp_data_in = 32'h0BAD0BAD;
    tick();
    chk_out("t2.done", 1'b1, 1'b1, 32'h0, 1'b1);
    chk("t2.no_start", 64'(unit_start), 64'h0);
    tick();
    cp_valid = 1'b0;
    chk_out("t2.idle", 1'b0, 1'b0, 32'h0, 1'b0);

    // 3: sel=0 never responds; timeout after 8 BUSY cycles
    cp_valid = 1'b1; cp_select = 2'd0; cp_data_in = 32'h33333333;
    tick();
    cp_valid = 1'b0;
    chk("t3.start", 64'(unit_start), 64'h1);
    for (int i = 0; i < 7; i++) tick();
    chk_out("t3.busy8", 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk_out("t3.timeout", 1'b1, 1'b1, 32'h0, 1'b1);
    unit_done = 3'b001; res0 = 32'h55555555;
    tick();
    unit_done = '0;
    chk_out("t3.late_done_held", 1'b1, 1'b1, 32'h0, 1'b1);
    cp_valid = 1'b1;
    tick();
    cp_valid = 1'b0;
    unit_done = 3'b001;
    tick();
    unit_done = '0;
    chk_out("t3.no_second", 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("t3.no_second2", 64'(cp_ready), 64'h0);

    // 4: sel=2, unit0 done ignored, unit2 done+error
    cp_valid = 1'b1; cp_select = 2'd2; cp_data_in = 32'h44444444;
    tick();
    chk("t4.start", 64'(unit_start), 64'h4);
    tick();
    unit_done = 3'b001; res0 = 32'h11111111;
    tick();
    unit_done = '0;
    chk_out("t4.ignore_u0", 1'b0, 1'b0, 32'h0, 1'b1);
    unit_done = 3'b100; unit_error = 3'b100; res2 = 32'h22223333;
    tick();
    unit_done = '0; unit_error = '0;
    chk_out("t4.done_err", 1'b1, 1'b1, 32'h22223333, 1'b1);
    tick();
    cp_valid = 1'b0;
    chk("t4.idle", 64'(cp_ready), 64'h0);

    // 5: back-to-back sel=0 then sel=1, result held while cp_valid low
    cp_valid = 1'b1; cp_select = 2'd0; cp_data_in = 32'hAAAA0000;
    tick();
    chk("t5a.start", 64'(unit_start), 64'h1);
    unit_done = 3'b001; res0 = 32'h0A0A0A0A;
    tick();
    unit_done = '0;
    chk_out("t5a.done", 1'b1, 1'b0, 32'h0A0A0A0A, 1'b1);
    cp_valid = 1'b0;
    tick();
    chk_out("t5a.hold1", 1'b1, 1'b0, 32'h0A0A0A0A, 1'b1);
    tick();
    chk_out("t5a.hold2", 1'b1, 1'b0, 32'h0A0A0A0A, 1'b1);
    cp_valid = 1'b1;
    tick();
    chk_out("t5a.idle", 1'b0, 1'b0, 32'h0, 1'b0);
    cp_select = 2'd1; cp_data_in = 32'hBBBB0000;
    tick();
    chk("t5b.start", 64'(unit_start), 64'h2);
    chk("t5b.operand", 64'(unit_operand), 64'hBBBB0000);
    unit_done = 3'b010; res1 = 32'h0B0B0B0B;
    tick();
    unit_done = '0;
    chk_out("t5b.done", 1'b1, 1'b0, 32'h0B0B0B0B, 1'b1);
    tick();
    cp_valid = 1'b0;
    chk("t5b.idle", 64'(cp_ready), 64'h0);

    // 6: reset while BUSY, then a fresh request
    cp_valid = 1'b1; cp_select = 2'd1; cp_data_in = 32'h66666666;
    tick(); tick();
    rst_n = 1'b0; cp_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("t6.reset", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t6.operand", 64'(unit_operand), 64'h0);
    chk("t6.start", 64'(unit_start), 64'h0);
    cp_valid = 1'b1; cp_select = 2'd0; cp_data_in = 32'hC0C0C0C0;
    tick();
    chk("t6.new_start", 64'(unit_start), 64'h1);
    unit_done = 3'b001; res0 = 32'h0C0C0C0C;
    tick();
    unit_done = '0;
    chk_out("t6.done", 1'b1, 1'b0, 32'h0C0C0C0C, 1'b1);
    tick();
    cp_valid = 1'b0;
    chk("t6.idle", 64'(cp_ready), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
